// File: rtl/usb_tx_packet_builder.sv
// USB TX packet builder: turns the controller's TX command into a byte stream
// for the bit serializer. The stream is SYNC, PID, payload and CRC16; handshake
// packets (ACK/NAK) stop after the PID.
module usb_tx_packet_builder #(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tx_packet,
    input  logic [6:0] tx_packet_data_size,
    input  logic       data_pid_sel,
    input  logic [7:0] buf_rd_data,
    output logic       buf_rd_en,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_SEND = 2'b01;
    localparam logic [1:0] CMD_NAK  = 2'b10;
    localparam logic [1:0] CMD_ACK  = 2'b11;

    localparam logic [7:0] MAX_SIZE  = 8'(MAX_BYTES);
    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  prev_cmd;
    logic [1:0]  cmd_q;
    logic        pid_sel_q;
    logic [6:0]  size_q;
    logic [6:0]  count;
    logic [15:0] crc;
    logic        error_q;
    logic        start;
    logic        size_bad;
    logic        accept;
    logic        handshake;
    logic [7:0]  pid_byte;

    // USB CRC16, reflected polynomial 0xA001, data consumed LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // A start is a new non-idle command level; holding a command does not retrigger
    assign start     = (tx_packet != CMD_IDLE) && (tx_packet != prev_cmd);
    assign size_bad  = (tx_packet == CMD_SEND) && ({1'b0, tx_packet_data_size} > MAX_SIZE);
    assign accept    = start && (state == S_IDLE) && !size_bad;
    assign handshake = byte_valid && byte_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every non-idle state advances only on a handshake
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_SYNC;
            end
            S_SYNC: begin
                if (handshake) state_next = S_PID;
            end
            S_PID: begin
                if (handshake) begin
                    if (cmd_q != CMD_SEND) begin
                        state_next = S_IDLE;
                    end else if (size_q == 7'd0) begin
                        state_next = S_CRC_LO;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (handshake && ((count + 7'd1) == size_q)) state_next = S_CRC_LO;
            end
            S_CRC_LO: begin
                if (handshake) state_next = S_CRC_HI;
            end
            S_CRC_HI: begin
                if (handshake) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // PID byte for the packet captured at start
    always_comb begin
        pid_byte = PID_DATA0;
        case (cmd_q)
            CMD_ACK:  pid_byte = PID_ACK;
            CMD_NAK:  pid_byte = PID_NAK;
            default:  pid_byte = pid_sel_q ? PID_DATA1 : PID_DATA0;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        buf_rd_en  = 1'b0;
        case (state)
            S_SYNC: begin
                byte_valid = 1'b1;
                byte_data  = SYNC_BYTE;
            end
            S_PID: begin
                byte_valid = 1'b1;
                byte_data  = pid_byte;
                byte_last  = (cmd_q != CMD_SEND);
            end
            S_DATA: begin
                byte_valid = 1'b1;
                byte_data  = buf_rd_data;
                buf_rd_en  = byte_ready;
            end
            S_CRC_LO: begin
                byte_valid = 1'b1;
                byte_data  = ~crc[7:0];
            end
            S_CRC_HI: begin
                byte_valid = 1'b1;
                byte_data  = ~crc[15:8];
                byte_last  = 1'b1;
            end
            default: ;
        endcase
        tx_busy  = (state != S_IDLE);
        tx_done  = byte_last && byte_ready;
        tx_error = error_q;
    end

    // Command edge tracking, packet parameters, payload count and running CRC
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cmd  <= CMD_IDLE;
            cmd_q     <= CMD_IDLE;
            pid_sel_q <= 1'b0;
            size_q    <= 7'd0;
            count     <= 7'd0;
            crc       <= 16'hFFFF;
            error_q   <= 1'b0;
        end else begin
            prev_cmd <= tx_packet;
            error_q  <= start && ((state != S_IDLE) || size_bad);
            if (accept) begin
                cmd_q     <= tx_packet;
                pid_sel_q <= data_pid_sel;
                size_q    <= tx_packet_data_size;
                count     <= 7'd0;
                crc       <= 16'hFFFF;
            end else if ((state == S_DATA) && handshake) begin
                count <= count + 7'd1;
                crc   <= crc16_byte(crc, buf_rd_data);
            end
        end
    end

endmodule
